// File: rtl/jtag_mem_bridge.sv
// Single-chain JTAG-to-memory bridge: one USER DR carries opcode/address/data,
// drives a synchronous memory port in the TCK domain with optional auto-increment.
module jtag_mem_bridge #(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 32,
  parameter int READ_LATENCY = 1,
  parameter int AUTO_INC     = 1
) (
  input  logic                  TCK,
  input  logic                  RESET,
  input  logic                  SEL,
  input  logic                  CAPTURE,
  input  logic                  SHIFT,
  input  logic                  UPDATE,
  input  logic                  TDI,
  output logic                  TDO,
  output logic                  WREN,
  output logic                  RDEN,
  output logic [ADDR_WIDTH-1:0] ADDR,
  output logic [DATA_WIDTH-1:0] TO_MEM,
  input  logic [DATA_WIDTH-1:0] FROM_MEM,
  output logic                  BUSY,
  output logic                  ERR
);

  localparam int DR_W = 2 + ADDR_WIDTH + DATA_WIDTH;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WR      = 2'd1;
  localparam logic [1:0] ST_RD_WAIT = 2'd2;

  localparam logic [1:0] OP_NOP     = 2'b00;
  localparam logic [1:0] OP_SETADDR = 2'b01;
  localparam logic [1:0] OP_WRITE   = 2'b10;
  localparam logic [1:0] OP_READ    = 2'b11;

  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = (AUTO_INC != 0) ? ADDR_WIDTH'(1) : '0;
  localparam logic [3:0]            LAT_LAST  = 4'(READ_LATENCY);

  logic [DR_W-1:0]       sr_reg;
  logic [1:0]            state_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] to_mem_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;
  logic                  wren_reg;
  logic                  rden_reg;
  logic                  err_reg;
  logic [3:0]            lat_cnt_reg;

  logic [1:0]            sr_op;
  logic [ADDR_WIDTH-1:0] sr_addr;
  logic [DATA_WIDTH-1:0] sr_data;
  logic                  busy;
  logic                  do_capture;
  logic                  do_shift;
  logic                  do_update;

  assign sr_op      = sr_reg[DR_W-1 -: 2];
  assign sr_addr    = sr_reg[DATA_WIDTH +: ADDR_WIDTH];
  assign sr_data    = sr_reg[DATA_WIDTH-1:0];
  assign busy       = (state_reg != ST_IDLE);
  assign do_capture = SEL & CAPTURE;
  assign do_shift   = SEL & SHIFT;
  assign do_update  = SEL & UPDATE;

  // Status sits in the top two bits so it leaves the chain last.
  always_ff @(posedge TCK) begin
    if (RESET) begin
      sr_reg <= '0;
    end else if (do_capture) begin
      sr_reg <= {err_reg, busy, addr_reg, rdata_reg};
    end else if (do_shift) begin
      sr_reg <= {TDI, sr_reg[DR_W-1:1]};
    end
  end

  always_ff @(posedge TCK) begin
    if (RESET) begin
      state_reg   <= ST_IDLE;
      addr_reg    <= '0;
      to_mem_reg  <= '0;
      rdata_reg   <= '0;
      wren_reg    <= 1'b0;
      rden_reg    <= 1'b0;
      err_reg     <= 1'b0;
      lat_cnt_reg <= '0;
    end else begin
      wren_reg <= 1'b0;
      rden_reg <= 1'b0;
      if (do_capture) err_reg <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (do_update) begin
            case (sr_op)
              OP_SETADDR: addr_reg <= sr_addr;
              OP_WRITE: begin
                to_mem_reg <= sr_data;
                wren_reg   <= 1'b1;
                state_reg  <= ST_WR;
              end
              OP_READ: begin
                rden_reg    <= 1'b1;
                lat_cnt_reg <= '0;
                state_reg   <= ST_RD_WAIT;
              end
              default: ;
            endcase
          end
        end
        ST_WR: begin
          addr_reg  <= addr_reg + ADDR_STEP;
          state_reg <= ST_IDLE;
        end
        ST_RD_WAIT: begin
          // Count starts in the RDEN cycle, so FROM_MEM is sampled READ_LATENCY cycles later.
          if (lat_cnt_reg == LAT_LAST) begin
            rdata_reg <= FROM_MEM;
            addr_reg  <= addr_reg + ADDR_STEP;
            state_reg <= ST_IDLE;
          end else begin
            lat_cnt_reg <= lat_cnt_reg + 4'd1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase

      // A command arriving mid-access is dropped; the error wins over a capture clear.
      if (do_update && busy) err_reg <= 1'b1;
    end
  end

  assign TDO    = sr_reg[0];
  assign WREN   = wren_reg;
  assign RDEN   = rden_reg;
  assign ADDR   = addr_reg;
  assign TO_MEM = to_mem_reg;
  assign BUSY   = busy;
  assign ERR    = err_reg;

endmodule

// File: tb/tb_jtag_mem_bridge.sv
// Randomised bench for jtag_mem_bridge: a transaction-level model predicts every
// output cycle by cycle; a few directed scenarios pin the model with literals.
module tb_jtag_mem_bridge;

  localparam int DW  = 64;
  localparam int AW  = 32;
  localparam int L   = 3;
  localparam int DRW = 2 + AW + DW;

  logic TCK = 1'b0;
  logic RESET, SEL, CAPTURE, SHIFT, UPDATE, TDI;
  logic TDO, WREN, RDEN, BUSY, ERR;
  logic [AW-1:0] ADDR;
  logic [DW-1:0] TO_MEM, FROM_MEM;

  always #5 TCK = ~TCK;

  jtag_mem_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(L), .AUTO_INC(1)) dut (
    .TCK(TCK), .RESET(RESET), .SEL(SEL), .CAPTURE(CAPTURE), .SHIFT(SHIFT),
    .UPDATE(UPDATE), .TDI(TDI), .TDO(TDO), .WREN(WREN), .RDEN(RDEN),
    .ADDR(ADDR), .TO_MEM(TO_MEM), .FROM_MEM(FROM_MEM), .BUSY(BUSY), .ERR(ERR)
  );

  int     n_vec = 0;
  int     n_bad = 0;
  longint cyc   = 0;
  always @(posedge TCK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory contents: a fixed pattern until written.
  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {a ^ 32'hA5A5_0F0F, ~a};
  endfunction

  logic [DW-1:0] env_mem [logic [AW-1:0]];
  logic [DW-1:0] mdl_mem [logic [AW-1:0]];

  function automatic logic [DW-1:0] env_rd(input logic [AW-1:0] a);
    return env_mem.exists(a) ? env_mem[a] : pat(a);
  endfunction
  function automatic logic [DW-1:0] mdl_rd(input logic [AW-1:0] a);
    return mdl_mem.exists(a) ? mdl_mem[a] : pat(a);
  endfunction

  // Memory device: FROM_MEM carries the word only in cycle L after RDEN, noise otherwise.
  int            rk = -1;
  logic [AW-1:0] ra = '0;
  always @(negedge TCK) begin
    if (WREN) env_mem[ADDR] = TO_MEM;
    if (RDEN) begin
      rk = 0;
      ra = ADDR;
    end else if (rk >= 0 && rk < 100) begin
      rk++;
    end
    FROM_MEM = (rk == L) ? env_rd(ra) : {$urandom, $urandom};
  end

  // Model: state after the in-flight access completes, plus the value shown while busy.
  logic [AW-1:0] m_addr, m_addr_prev;
  logic [DW-1:0] m_rdata, m_rdata_prev, m_to_mem;
  bit            m_err;
  int            m_op;
  longint        m_op_cyc, m_busy_end;

  bit            e_busy, e_err;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_rdata;
  bit            cmp_on  = 0;
  bit            tdo_chk = 0;
  bit            exp_tdo = 0;

  task automatic model_reset();
    m_addr = '0; m_addr_prev = '0; m_rdata = '0; m_rdata_prev = '0; m_to_mem = '0;
    m_err = 0; m_op = 0; m_op_cyc = -1; m_busy_end = 0;
  endtask

  // Called just after the edge that sampled UPDATE.
  task automatic model_update(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
    longint n = cyc;
    if (n <= m_busy_end) begin
      m_err = 1;
    end else begin
      case (op)
        2'b01: begin m_addr = a; m_addr_prev = a; end
        2'b10: begin
          m_op = 2; m_op_cyc = n; m_busy_end = n + 1;
          m_to_mem = d; mdl_mem[m_addr] = d;
          m_rdata_prev = m_rdata;
          m_addr_prev = m_addr; m_addr = m_addr + 1;
        end
        2'b11: begin
          m_op = 3; m_op_cyc = n; m_busy_end = n + L + 1;
          m_rdata_prev = m_rdata; m_rdata = mdl_rd(m_addr);
          m_addr_prev = m_addr; m_addr = m_addr + 1;
        end
        default: ;
      endcase
    end
  endtask

  always @(negedge TCK) begin
    e_busy  = (cyc < m_busy_end);
    e_addr  = e_busy ? m_addr_prev : m_addr;
    e_rdata = e_busy ? m_rdata_prev : m_rdata;
    e_err   = m_err;
    if (cmp_on) begin
      check("busy",   128'(BUSY),   128'(e_busy));
      check("err",    128'(ERR),    128'(e_err));
      check("addr",   128'(ADDR),   128'(e_addr));
      check("to_mem", 128'(TO_MEM), 128'(m_to_mem));
      check("wren",   128'(WREN),   128'(m_op == 2 && cyc == m_op_cyc));
      check("rden",   128'(RDEN),   128'(m_op == 3 && cyc == m_op_cyc));
      if (tdo_chk) check("tdo", 128'(TDO), 128'(exp_tdo));
    end
  end

  task automatic tick();
    @(posedge TCK);
    #1;
  endtask

  logic [1:0]    last_op;
  logic [AW-1:0] last_a;
  logic [DW-1:0] last_d;

  task automatic scan(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      output logic [DRW-1:0] got);
    logic [DRW-1:0] tx, cap;
    tx = {op, a, d};
    SEL = 1; CAPTURE = 1;
    tick();
    cap = {e_err, e_busy, e_addr, e_rdata};
    m_err = 0;
    CAPTURE = 0; SHIFT = 1;
    for (int i = 0; i < DRW; i++) begin
      TDI = tx[i]; exp_tdo = cap[i]; tdo_chk = 1;
      got[i] = TDO;
      tick();
    end
    tdo_chk = 0; SHIFT = 0; UPDATE = 1;
    tick();
    UPDATE = 0;
    model_update(op, a, d);
    last_op = op; last_a = a; last_d = d;
    $display("scan op=%0d addr=%h data=%h captured=%h", op, a, d, got);
  endtask

  // Re-issue the last command straight after its update, with no new shift.
  task automatic bump();
    UPDATE = 1;
    tick();
    UPDATE = 0;
    model_update(last_op, last_a, last_d);
  endtask

  task automatic do_reset();
    RESET = 1;
    tick();
    model_reset();
    RESET = 0;
  endtask

  task automatic noise();
    SEL = 0;
    repeat (4) begin
      CAPTURE = 1'($urandom); SHIFT = 1'($urandom); UPDATE = 1'($urandom); TDI = 1'($urandom);
      tick();
    end
    CAPTURE = 0; SHIFT = 0; UPDATE = 0; SEL = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_bad);
    $fatal(1, "timeout");
  end

  initial begin
    logic [DRW-1:0] got;
    logic [DW-1:0]  rd;
    int busy_cnt, rden_cnt, r;
    logic [1:0]     op;
    logic [AW-1:0]  a;

    RESET = 1; SEL = 0; CAPTURE = 0; SHIFT = 0; UPDATE = 0; TDI = 0;
    model_reset();
    repeat (3) tick();
    RESET = 0;
    cmp_on = 1;

    // Reset state and an all-zero capture.
    check("rst_wren", 128'(WREN), 128'(0));
    check("rst_busy", 128'(BUSY), 128'(0));
    check("rst_err",  128'(ERR),  128'(0));
    check("rst_tdo",  128'(TDO),  128'(0));
    scan(2'b00, 32'h0, 64'h0, got);
    check("rst_stream", 128'(got), 128'(0));

    // SETADDR then WRITE; the WRITE's addr field is ignored.
    scan(2'b01, 32'h0000_1000, 64'h0, got);
    scan(2'b10, 32'h5555_5555, 64'hDEAD_BEEF_CAFE_F00D, got);
    check("wr_pulse",  128'(WREN),   128'(1));
    check("wr_addr",   128'(ADDR),   128'(32'h0000_1000));
    check("wr_data",   128'(TO_MEM), 128'(64'hDEAD_BEEF_CAFE_F00D));
    tick();
    check("wr_inc",    128'(ADDR),   128'(32'h0000_1001));
    check("wr_single", 128'(WREN),   128'(0));

    // READ with latency 3: one RDEN, four BUSY cycles, data on the next capture.
    scan(2'b01, 32'h0000_1000, 64'h0, got);
    scan(2'b10, 32'h0, 64'h1122_3344_5566_7788, got);
    scan(2'b01, 32'h0000_1000, 64'h0, got);
    scan(2'b11, 32'h0, 64'h0, got);
    busy_cnt = 0; rden_cnt = 0;
    repeat (20) begin
      busy_cnt += int'(BUSY);
      rden_cnt += int'(RDEN);
      tick();
    end
    check("rd_busy_cycles", 128'(busy_cnt), 128'(4));
    check("rd_rden_cycles", 128'(rden_cnt), 128'(1));
    scan(2'b00, 32'h0, 64'h0, got);
    check("rd_capture", 128'(got), 128'({2'b00, 32'h0000_1001, 64'h1122_3344_5566_7788}));

    // Burst of writes across the address wrap.
    scan(2'b01, 32'hFFFF_FFFE, 64'h0, got);
    scan(2'b10, 32'h0, 64'hAAAA_0000_0000_0001, got);
    scan(2'b10, 32'h0, 64'hAAAA_0000_0000_0002, got);
    scan(2'b10, 32'h0, 64'hAAAA_0000_0000_0003, got);
    tick();
    check("burst_addr", 128'(ADDR), 128'(32'h0000_0001));
    check("burst_m0", 128'(env_rd(32'hFFFF_FFFE)), 128'(64'hAAAA_0000_0000_0001));
    check("burst_m1", 128'(env_rd(32'hFFFF_FFFF)), 128'(64'hAAAA_0000_0000_0002));
    check("burst_m2", 128'(env_rd(32'h0000_0000)), 128'(64'hAAAA_0000_0000_0003));

    // Command during RD_WAIT is dropped and flags a read-to-clear error.
    scan(2'b11, 32'h0, 64'h0, got);
    bump();
    repeat (10) tick();
    scan(2'b00, 32'h0, 64'h0, got);
    check("err_status", 128'(got[DRW-1 -: 2]), 128'(2'b10));
    scan(2'b00, 32'h0, 64'h0, got);
    check("err_cleared", 128'(got[DRW-1 -: 2]), 128'(2'b00));

    // Reset mid-read discards the access; deselected strobes do nothing.
    scan(2'b01, 32'h0000_1234, 64'h0, got);
    scan(2'b11, 32'h0, 64'h0, got);
    tick();
    do_reset();
    check("rst_mid_busy", 128'(BUSY), 128'(0));
    check("rst_mid_rden", 128'(RDEN), 128'(0));
    check("rst_mid_addr", 128'(ADDR), 128'(0));
    repeat (L + 3) tick();
    noise();
    noise();
    scan(2'b00, 32'h0, 64'h0, got);
    check("rst_mid_capture", 128'(got), 128'(0));

    // Randomised traffic checked cycle by cycle against the model.
    for (int it = 0; it < 150; it++) begin
      r = int'($urandom_range(0, 99));
      a = (($urandom_range(0, 3)) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
      if (r < 15)      op = 2'b01;
      else if (r < 50) op = 2'b10;
      else if (r < 85) op = 2'b11;
      else             op = 2'b00;
      rd = {$urandom, $urandom};
      scan(op, a, rd, got);
      if ($urandom_range(0, 4) == 0) bump();
      repeat ($urandom_range(0, L + 2)) tick();
      if ($urandom_range(0, 9) == 0) noise();
      if ($urandom_range(0, 29) == 0) do_reset();
    end
    repeat (L + 3) tick();
    scan(2'b00, 32'h0, 64'h0, got);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/jtag_mem_bridge.md
Name: jtag_mem_bridge

Overview:
- Single-chain, parametrised JTAG-to-memory bridge; supersedes the two-chain ROM/address pair.
- One USER DR carries opcode, address and data. Supports set-address, write and read with a configurable memory read latency.
- Optional address auto-increment enables burst transfers. Errors are reported back on the next capture.
- Sits between a bscan_generic instance (buffered TCK) and a synchronous memory port in the TCK domain.

Parameters:
DATA_WIDTH, 64, memory word width in bits.
ADDR_WIDTH, 32, word-address width.
READ_LATENCY, 1, TCK cycles from read request to FROM_MEM valid; legal range 1..15.
AUTO_INC, 1, 1 = address += 1 after every WRITE/READ; 0 = address held.
DR_W, 2+ADDR_WIDTH+DATA_WIDTH, derived DR length; not overridable.

Ports:
TCK  in  1  buffered JTAG clock; the only clock.
RESET  in  1  synchronous, active-high reset.
SEL  in  1  USER instruction for this chain active.
CAPTURE  in  1  TAP in Capture-DR.
SHIFT  in  1  TAP in Shift-DR.
UPDATE  in  1  TAP in Update-DR.
TDI  in  1  serial data in.
TDO  out  1  serial data out.
WREN  out  1  one-cycle memory write strobe.
RDEN  out  1  one-cycle memory read strobe.
ADDR  out  ADDR_WIDTH  current word address.
TO_MEM  out  DATA_WIDTH  write data.
FROM_MEM  in  DATA_WIDTH  read data, valid READ_LATENCY cycles after RDEN.
BUSY  out  1  memory access in progress.
ERR  out  1  sticky error flag.

Behaviour:
- DR layout, LSB first out: [DATA_WIDTH-1:0] data; next ADDR_WIDTH bits addr; top 2 bits opcode (shift-in) or status (capture).
- Reset values: sr=0, addr=0, TO_MEM=0, rdata=0, WREN=0, RDEN=0, BUSY=0, ERR=0, state=IDLE. TDO=sr[0], so TDO=0.
- Capture (SEL&CAPTURE): sr <= {ERR, BUSY, addr, rdata}. ERR clears in the same cycle, i.e. a read-to-clear.
- Shift (SEL&SHIFT): sr <= {TDI, sr[DR_W-1:1]}. TDO is combinational from sr[0].
- CAPTURE, SHIFT and UPDATE are ignored when SEL=0.
- Update (SEL&UPDATE), state IDLE, decodes opcode sr[DR_W-1:DR_W-2]:
  - 00 NOP: no action.
  - 01 SETADDR: addr <= sr addr field.
  - 10 WRITE: TO_MEM <= data field; next cycle WREN=1 for exactly 1 cycle at the current addr; state WR → IDLE; then addr increments if AUTO_INC.
  - 11 READ: next cycle RDEN=1 for 1 cycle; state RD_WAIT. A latency counter counts READ_LATENCY cycles, then rdata <= FROM_MEM; state → IDLE; then addr increments if AUTO_INC.
- The READ address is the addr value at the time of the UPDATE. Read data is returned in the *next* Capture-DR.
- BUSY=1 in WR and RD_WAIT states.
- UPDATE while BUSY: the command is dropped and ERR <= 1.
- Increment: addr <= addr+1 modulo 2^ADDR_WIDTH; wraps all-ones → 0 with no error.
- The addr field of WRITE/READ commands is ignored; only SETADDR loads addr.
- CAPTURE during RD_WAIT returns the old rdata with BUSY=1 in status.
- RESET mid-access: WREN/RDEN deassert on the next edge, state → IDLE, and the pending rdata update is discarded.
- ADDR output mirrors the addr register. TO_MEM holds its value until the next WRITE.

Test Plan:
- Reset, then a Capture/Shift of 98 bits → TDO stream all zeros; WREN=RDEN=BUSY=ERR=0.
- SETADDR 0x00001000; WRITE 0xDEADBEEF_CAFEF00D → one WREN pulse with ADDR=0x1000 and TO_MEM=that value; ADDR then 0x1001.
- READ_LATENCY=3: SETADDR 0x1000, READ, model returns 0x1122334455667788 → RDEN 1 cycle, BUSY high 4 cycles; next capture shifts out data 0x1122334455667788, addr 0x1001, status 00.
- Burst: SETADDR 0xFFFFFFFE, WRITE ×3 → writes at 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000; final ADDR=0x00000001.
- With READ_LATENCY=15, issue READ then an immediate WRITE during RD_WAIT → no WREN. Next capture status=10 (ERR=1, BUSY=0); the following capture status=00.
- Assert RESET during RD_WAIT → RDEN/BUSY low next cycle, rdata stays 0, ADDR=0; SEL=0 with UPDATE pulses → no activity.
